// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle widths, machine word sizes and
// the packed per-stage control bundles carried between pipeline stages.
package pipe_pkg;

  localparam int EX_CTRL_W  = 9;
  localparam int MEM_CTRL_W = 2;
  localparam int WB_CTRL_W  = 5;
  localparam int REG_SIZE   = 5;
  localparam int WORD_SIZE  = 32;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic       shift;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [2:0] wb_sel;
  } wb_ctrl_t;

  // Field order puts the earliest-consumed bundle in the low bits.
  typedef struct packed {
    wb_ctrl_t  wb;
    mem_ctrl_t mem;
    ex_ctrl_t  ex;
  } stage_ctrl_t;

  localparam int STAGE_CTRL_W = EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: data + control register with a valid bit.
// clear has priority over load; ctrl_zero stores the control bundle as zero.
module pipe_entry_reg #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic              clear,
  input  logic              ctrl_zero,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      // Payload is kept so the last value stays visible after draining.
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= ctrl_zero ? '0 : d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with valid/ready flow control, flush, bubble insertion
// and a saturating stall counter. Define PIPE_STAGE_SKID_EN for a skid entry.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int CTRL_W = STAGE_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high; upstream may drop or change its offer whenever in_ready is low.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              accept;
  logic              drain;
  logic              out_load;
  logic              out_clear;
  logic              out_zero;
  logic [DATA_W-1:0] out_d_data;
  logic [CTRL_W-1:0] out_d_ctrl;

  assign accept = in_valid & in_ready & ~flush;
  assign drain  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              out_take;
  logic              skid_load;
  logic              skid_clear;

  // in_ready comes straight from a flop: no path from out_ready.
  assign in_ready   = ~skid_valid;
  assign out_take   = ~out_valid | out_ready;
  assign out_load   = out_take & (skid_valid | accept);
  assign out_d_data = skid_valid ? skid_data : in_data;
  assign out_d_ctrl = skid_valid ? skid_ctrl : in_ctrl;
  // The skid entry already had its bubble applied when it was captured.
  assign out_zero   = ~skid_valid & bubble;
  assign out_clear  = flush | (drain & ~out_load);
  assign skid_load  = accept & ~out_take;
  assign skid_clear = flush | (skid_valid & out_take);

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .ctrl_zero (bubble),
    .d_data    (in_data),
    .d_ctrl    (in_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );
`else
  assign in_ready   = ~out_valid | out_ready;
  assign out_load   = accept;
  assign out_d_data = in_data;
  assign out_d_ctrl = in_ctrl;
  assign out_zero   = bubble;
  assign out_clear  = flush | (drain & ~accept);
`endif

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_out (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (out_load),
    .clear     (out_clear),
    .ctrl_zero (out_zero),
    .d_data    (out_d_data),
    .d_ctrl    (out_d_ctrl),
    .valid     (out_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

  // Counts the pre-flush view of the stage, so a flushed stall still counts.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic (CNT_W=4 so saturation is reachable).
// Expectations follow the skid variant when PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 48;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              Clk;
  logic              Reset;
  logic              flush;
  logic              bubble;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int checks;
  int failures;

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (flush),
    .bubble    (bubble),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    flush    = 1'b0;
    bubble   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("init_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-stream with a valid entry held
    in_valid = 1'b1;
    in_data  = 48'h55;
    in_ctrl  = 16'h1234;
    tick();
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    chk("pre_reset_data", 64'(out_data), 64'h55);
    in_valid = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming 1..8 with out_ready held high: one transfer per cycle
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 48'(i);
      in_ctrl  = 16'(i * 16'h0101);
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_ctrl", 64'(out_ctrl), 64'(i * 16'h0101));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(out_valid), 64'd0);
    chk("stream_hold_data", 64'(out_data), 64'd8);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: hold 0xAA for 3 stalled cycles while 0xBB is offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'hAA;
    in_ctrl   = 16'h00A0;
    tick();
    in_data = 48'hBB;
    in_ctrl = 16'h00B0;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_in_ready_first", 64'(in_ready), 64'd1);
`else
    chk("bp_in_ready_first", 64'(in_ready), 64'd0);
`endif
    tick();
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    tick();
    tick();
    chk("bp_hold_data", 64'(out_data), 64'hAA);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_release_valid", 64'(out_valid), 64'd1);
    chk("bp_release_data", 64'(out_data), 64'hBB);
    tick();
`endif
    chk("bp_after_valid", 64'(out_valid), 64'd0);
    chk("bp_after_stall", 64'(stall_cnt), 64'd3);

    // Bubble zeroes control of the accepted entry only
    in_valid = 1'b1;
    in_data  = 48'h1234_5678_9ABC;
    in_ctrl  = 16'hFFFF;
    bubble   = 1'b1;
    tick();
    chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    chk("bubble_data", 64'(out_data), 64'h1234_5678_9ABC);
    chk("bubble_valid", 64'(out_valid), 64'd1);
    bubble  = 1'b0;
    in_data = 48'hDEAD;
    tick();
    chk("nobubble_ctrl", 64'(out_ctrl), 64'hFFFF);
    chk("nobubble_data", 64'(out_data), 64'hDEAD);
    in_valid = 1'b0;
    bubble   = 1'b1;
    tick();
    chk("idle_bubble_valid", 64'(out_valid), 64'd0);
    chk("idle_bubble_ctrl", 64'(out_ctrl), 64'hFFFF);
    bubble = 1'b0;

    // Flush with the stage full (and skid full when present) plus an offer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'h11;
    in_ctrl   = 16'h0001;
    tick();
    in_data = 48'h22;
    tick();
    chk("flush_pre_stall", 64'(stall_cnt), 64'd4);
    in_data = 48'h33;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_stall", 64'(stall_cnt), 64'd5);
    out_ready = 1'b1;
    tick();
    chk("flush_no_emerge1", 64'(out_valid), 64'd0);
    tick();
    chk("flush_no_emerge2", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // Flush while empty leaves the stage empty and accepting
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty_valid", 64'(out_valid), 64'd0);

    // Saturation of the 4-bit stall counter
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'h77;
    in_ctrl   = 16'h0007;
    tick();
    in_valid = 1'b0;
    chk("sat_start", 64'(stall_cnt), 64'd5);
    for (int i = 0; i < 9; i++) tick();
    chk("sat_14", 64'(stall_cnt), 64'd14);
    tick();
    chk("sat_15", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_hold", 64'(stall_cnt), 64'd15);
    chk("sat_data", 64'(out_data), 64'h77);

    // Only reset clears the counter
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("final_rst_stall", 64'(stall_cnt), 64'd0);
    chk("final_rst_valid", 64'(out_valid), 64'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
